accel_spi_responder: RTL

ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

---
 rtl/accel_spi_pkg.sv | 46 ++++
 rtl/spi_edge_sync.sv | 52 +++++
 rtl/accel_spi_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/accel_spi_pkg.sv
// Shared constants, register map and FSM state type for the accelerometer SPI responder.
package accel_spi_pkg;

  localparam logic [7:0] CmdWrite    = 8'h0A;
  localparam logic [7:0] CmdRead     = 8'h0B;
  localparam logic [7:0] CmdFifoRead = 8'h0D;

  localparam logic [7:0] DevIdAd  = 8'hAD;
  localparam logic [7:0] DevIdMst = 8'h1D;
  localparam logic [7:0] RevId    = 8'h01;

  localparam logic [5:0] AddrDevIdAd   = 6'h00;
  localparam logic [5:0] AddrDevIdMst  = 6'h01;
  localparam logic [5:0] AddrPartId    = 6'h02;
  localparam logic [5:0] AddrRevId     = 6'h03;
  localparam logic [5:0] AddrXdataL    = 6'h0E;
  localparam logic [5:0] AddrXdataH    = 6'h0F;
  localparam logic [5:0] AddrYdataL    = 6'h10;
  localparam logic [5:0] AddrYdataH    = 6'h11;
  localparam logic [5:0] AddrZdataL    = 6'h12;
  localparam logic [5:0] AddrZdataH    = 6'h13;
  localparam logic [5:0] AddrSoftReset = 6'h1F;
  localparam logic [5:0] AddrStoreLo   = 6'h20;
  localparam logic [5:0] AddrPowerCtl  = 6'h2D;
  localparam logic [5:0] AddrStoreHi   = 6'h2E;

  localparam logic [7:0] SoftResetKey = 8'h52;

  // Storage 0x20..0x2E is indexed by the low address nibble.
  localparam int unsigned NumStore    = 15;
  localparam logic [3:0]  PowerCtlIdx = 4'hD;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWdata,
    StRdata,
    StIgnore
  } state_e;

  function automatic logic is_store(input logic [5:0] addr);
    return (addr >= AddrStoreLo) && (addr <= AddrStoreHi);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes SCLK/CSN/MOSI into the system clock domain and produces single-cycle edge pulses.
module spi_edge_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic csn_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic csn_fall_o,
  output logic csn_rise_o,
  output logic mosi_o
);

  logic [SyncStages-1:0] sclk_sync_q;
  logic [SyncStages-1:0] csn_sync_q;
  logic [SyncStages-1:0] mosi_sync_q;
  logic                  sclk_prev_q;
  logic                  csn_prev_q;

  logic sclk_s;
  logic csn_s;

  assign sclk_s = sclk_sync_q[SyncStages-1];
  assign csn_s  = csn_sync_q[SyncStages-1];

  // CSN resets low so a select held low across reset release is not seen as a fresh fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], sclk_i};
      csn_sync_q  <= {csn_sync_q[SyncStages-2:0], csn_i};
      mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], mosi_i};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sclk_rise_o = sclk_s & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_s & sclk_prev_q;
  assign csn_fall_o  = ~csn_s & csn_prev_q;
  assign csn_rise_o  = csn_s & ~csn_prev_q;
  assign mosi_o      = mosi_sync_q[SyncStages-1];

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-0 register responder emulating an accelerometer; the soft-reset register at 0x1F
// exists only when ACCEL_RESP_SOFTRESET_EN is defined.
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic               CLK100MHZ,
  input  logic               rst_n,
  input  logic               ACL_SCLK,
  input  logic               ACL_CSN,
  input  logic               ACL_MOSI,
  output logic               ACL_MISO,
  input  logic signed [15:0] x_val,
  input  logic signed [15:0] y_val,
  input  logic signed [15:0] z_val,
  output logic [7:0]         power_ctl,
  output logic               txn_done,
  output logic               txn_err
);

  logic sclk_rise;
  logic sclk_fall;
  logic csn_fall;
  logic csn_rise;
  logic mosi_s;

  spi_edge_sync #(
    .SyncStages(SYNC_STAGES)
  ) u_edge_sync (
    .clk_i      (CLK100MHZ),
    .rst_ni     (rst_n),
    .sclk_i     (ACL_SCLK),
    .csn_i      (ACL_CSN),
    .mosi_i     (ACL_MOSI),
    .sclk_rise_o(sclk_rise),
    .sclk_fall_o(sclk_fall),
    .csn_fall_o (csn_fall),
    .csn_rise_o (csn_rise),
    .mosi_o     (mosi_s)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        got_byte_q, got_byte_d;
  logic        wr_mode_q, wr_mode_d;
  logic [15:0] snap_x_q, snap_x_d;
  logic [15:0] snap_y_q, snap_y_d;
  logic [15:0] snap_z_q, snap_z_d;
  logic [7:0]  store_q [NumStore];
  logic [7:0]  store_d [NumStore];

  logic [7:0]  rx_byte;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;

  assign rx_byte = {rx_q, mosi_s};

  // The first read byte is fetched from the address just received; later ones from addr_q + 1.
  assign rd_addr = (state_q == StAddr) ? rx_byte[5:0] : addr_q + 6'd1;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      AddrDevIdAd:  rd_data = DevIdAd;
      AddrDevIdMst: rd_data = DevIdMst;
      AddrPartId:   rd_data = PARTID;
      AddrRevId:    rd_data = RevId;
      AddrXdataL:   rd_data = snap_x_q[7:0];
      AddrXdataH:   rd_data = snap_x_q[15:8];
      AddrYdataL:   rd_data = snap_y_q[7:0];
      AddrYdataH:   rd_data = snap_y_q[15:8];
      AddrZdataL:   rd_data = snap_z_q[7:0];
      AddrZdataH:   rd_data = snap_z_q[15:8];
      default: begin
        if (is_store(rd_addr)) begin
          rd_data = store_q[rd_addr[3:0]];
        end
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    got_byte_d = got_byte_q;
    wr_mode_d  = wr_mode_q;
    snap_x_d   = snap_x_q;
    snap_y_d   = snap_y_q;
    snap_z_d   = snap_z_q;
    store_d    = store_q;

    if (csn_rise) begin
      // Any partial byte in rx_q is simply dropped here.
      state_d    = StIdle;
      bit_cnt_d  = 3'd0;
      rx_d       = '0;
      miso_d     = 1'b0;
      done_d     = (state_q != StIdle) && got_byte_q;
      got_byte_d = 1'b0;
    end else if (csn_fall) begin
      state_d    = StCmd;
      bit_cnt_d  = 3'd0;
      rx_d       = '0;
      miso_d     = 1'b0;
      got_byte_d = 1'b0;
      snap_x_d   = x_val;
      snap_y_d   = y_val;
      snap_z_d   = z_val;
    end else if (state_q != StIdle) begin
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          got_byte_d = 1'b1;
          unique case (state_q)
            StCmd: begin
              if (rx_byte == CmdWrite) begin
                state_d   = StAddr;
                wr_mode_d = 1'b1;
              end else if (rx_byte == CmdRead) begin
                state_d   = StAddr;
                wr_mode_d = 1'b0;
              end else begin
                state_d = StIgnore;
                err_d   = 1'b1;
              end
            end
            StAddr: begin
              addr_d = rx_byte[5:0];
              if (wr_mode_q) begin
                state_d = StWdata;
              end else begin
                state_d = StRdata;
                tx_d    = rd_data;
              end
            end
            StWdata: begin
              if (is_store(addr_q)) begin
                store_d[addr_q[3:0]] = rx_byte;
              end
`ifdef ACCEL_RESP_SOFTRESET_EN
              else if ((addr_q == AddrSoftReset) && (rx_byte == SoftResetKey)) begin
                store_d = '{default: '0};
              end
`endif
              addr_d = addr_q + 6'd1;
            end
            StRdata: begin
              addr_d = addr_q + 6'd1;
              tx_d   = rd_data;
            end
            default: ;
          endcase
        end
      end

      if (sclk_fall && (state_q == StRdata)) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      rx_q       <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      got_byte_q <= 1'b0;
      wr_mode_q  <= 1'b0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_z_q   <= '0;
      store_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      done_q     <= done_d;
      err_q      <= err_d;
      got_byte_q <= got_byte_d;
      wr_mode_q  <= wr_mode_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      snap_z_q   <= snap_z_d;
      store_q    <= store_d;
    end
  end

  assign ACL_MISO  = miso_q;
  assign power_ctl = store_q[PowerCtlIdx];
  assign txn_done  = done_q;
  assign txn_err   = err_q;

endmodule
